// File: rtl/pc_request_unit.sv
// Fetch front-end: owns the PC, issues instruction reads, turns control-unit
// decisions into registered data-memory requests, and freezes on HALT.
module pc_request_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] i_imemload,
   input  logic        i_ihit,
   input  logic        i_dhit,
   input  logic [2:0]  i_PCSrc,
   input  logic [31:0] i_rs_data,
   input  logic [15:0] i_immediate,
   input  logic [25:0] i_immediate26,
   input  logic        i_cu_dREN,
   input  logic        i_cu_dWEN,
   input  logic        i_halt_in,
   output logic [31:0] o_instruction,
   output logic [31:0] o_imemaddr,
   output logic        o_imemREN,
   output logic        o_dmemREN,
   output logic        o_dmemWEN,
   output logic [31:0] o_pc_plus4,
   output logic        o_halt,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      MEM    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_dmemREN;
   logic        r_dmemWEN;
   logic        r_halt;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_branch_off;
   logic [31:0] w_next_pc;
   logic        w_fetch_done;
   logic        w_data_req;

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_branch_off = {{14{i_immediate[15]}}, i_immediate, 2'b00};
   assign w_fetch_done = (r_state == FETCH) && i_ihit;
   assign w_data_req   = i_cu_dREN || i_cu_dWEN;

   // Undefined PCSrc codes fall through to sequential execution.
   always_comb begin
      w_next_pc = w_pc_plus4;
      case (i_PCSrc)
         3'd0:    w_next_pc = i_rs_data;
         3'd1:    w_next_pc = {w_pc_plus4[31:28], i_immediate26, 2'b00};
         3'd2:    w_next_pc = w_pc_plus4 + w_branch_off;
         default: w_next_pc = w_pc_plus4;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         FETCH: begin
            if (i_ihit) begin
               if (i_halt_in)       w_next_state = HALTED;
               else if (w_data_req) w_next_state = MEM;
            end
         end
         MEM: begin
            if (i_dhit) w_next_state = FETCH;
         end
         HALTED:  w_next_state = HALTED;
         default: w_next_state = FETCH;
      endcase
   end

   // While a data access or HALT is pending the control unit decodes the latched word.
   always_comb begin
      o_imemREN     = 1'b0;
      o_instruction = r_instr;
      case (r_state)
         FETCH: begin
            o_imemREN     = 1'b1;
            o_instruction = i_imemload;
         end
         default: begin
            o_imemREN     = 1'b0;
            o_instruction = r_instr;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc      <= PC_INIT;
         r_instr   <= 32'd0;
         r_dmemREN <= 1'b0;
         r_dmemWEN <= 1'b0;
         r_halt    <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (w_fetch_done) begin
                  if (i_halt_in) begin
                     r_halt  <= 1'b1;
                     r_instr <= i_imemload;
                  end else if (i_cu_dWEN) begin
                     r_dmemWEN <= 1'b1;
                     r_dmemREN <= 1'b0;
                     r_instr   <= i_imemload;
                  end else if (i_cu_dREN) begin
                     r_dmemREN <= 1'b1;
                     r_dmemWEN <= 1'b0;
                     r_instr   <= i_imemload;
                  end else begin
                     r_pc <= w_next_pc;
                  end
               end
            end
            MEM: begin
               if (i_dhit) begin
                  r_dmemREN <= 1'b0;
                  r_dmemWEN <= 1'b0;
                  r_pc      <= w_next_pc;
               end
            end
            HALTED: begin
               r_dmemREN <= 1'b0;
               r_dmemWEN <= 1'b0;
               r_halt    <= 1'b1;
            end
            default: begin
               r_dmemREN <= 1'b0;
               r_dmemWEN <= 1'b0;
            end
         endcase
      end
   end

   assign o_imemaddr = r_pc;
   assign o_pc_plus4 = w_pc_plus4;
   assign o_dmemREN  = r_dmemREN;
   assign o_dmemWEN  = r_dmemWEN;
   assign o_halt     = r_halt;
   assign o_state    = r_state;

   a_req_exclusive : assert property (@(posedge CLK) disable iff (!nRST)
      !(r_dmemREN && r_dmemWEN));

endmodule
